vga_text_console: RTL and testbench

//  Character-cell frame buffer and console engine upstream of the VGA text renderer.

---
 rtl/vga_text_console.sv | 174 +++++++++++++++++
 tb/tb_vga_text_console.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_console.sv
// Text console engine: decodes a char/colour byte stream into a circular-scroll
// cell RAM and serves the renderer with registered, logically addressed reads.
module vga_text_console #(
    parameter int COLS   = 96,
    parameter int ROWS   = 32,
    parameter int ADDR_W = 12,
    parameter int CW     = 8,
    localparam int XW    = $clog2(COLS),
    localparam int YW    = $clog2(ROWS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CW-1:0]     cmd_ch_i,
    input  logic [CW-1:0]     cmd_color_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic [CW-1:0]     ch_o,
    output logic [CW-1:0]     color_o,
    output logic [XW-1:0]     cursor_x_o,
    output logic [YW-1:0]     cursor_y_o,
    output logic              busy_o
);
    localparam int CELLS = COLS * ROWS;
    localparam int SW    = ADDR_W + 2;
    localparam logic [SW-1:0]   CELLS_S = SW'(CELLS);
    localparam logic [SW-1:0]   COLS_S  = SW'(COLS);
    localparam logic [2*CW-1:0] BLANK   = {CW'(32), CW'(0)};

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] swp_q, swp_d;
    logic [XW-1:0]     cx_q, cx_d;
    logic [YW-1:0]     cy_q, cy_d, top_q, top_d;
    logic              oob_q;
    logic [2*CW-1:0]   rd_q;
    logic [2*CW-1:0]   mem_q [CELLS];

    logic              we, accept, printable, new_line, rd_in;
    logic [ADDR_W-1:0] waddr, rd_phys;
    logic [2*CW-1:0]   wdata;
    logic [SW-1:0]     cur_lin, rd_lin;

    // Logical cell -> physical cell; the screen scrolls by rotating top_q.
    function automatic logic [ADDR_W-1:0] to_phys(input logic [SW-1:0] lin,
                                                  input logic [YW-1:0] top);
        logic [SW-1:0] sum;
        sum = lin + SW'(top) * COLS_S;
        if (sum >= CELLS_S) sum = sum - CELLS_S;
        return sum[ADDR_W-1:0];
    endfunction

    assign cmd_ready_o = (state_q == S_IDLE) & ~rst_i;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign busy_o      = (state_q != S_IDLE);
    assign cursor_x_o  = cx_q;
    assign cursor_y_o  = cy_q;

    always_comb begin
        state_d  = state_q;
        swp_d    = swp_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        top_d    = top_q;
        we       = 1'b0;
        waddr    = '0;
        wdata    = BLANK;
        new_line = 1'b0;
        cur_lin  = SW'(cy_q) * COLS_S + SW'(cx_q);
        printable = (cmd_ch_i >= CW'(32) && cmd_ch_i <= CW'(126)) || cmd_ch_i <= CW'(7)
                    || cmd_ch_i == CW'(9) || cmd_ch_i == CW'(11);
        case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                waddr = swp_q;
                if (swp_q == ADDR_W'(CELLS - 1)) begin
                    state_d = S_IDLE;
                    swp_d   = '0;
                end else begin
                    swp_d = swp_q + ADDR_W'(1);
                end
            end
            S_SCROLL: begin
                // top_q already advanced, so logical bottom row is the old top row
                we    = 1'b1;
                waddr = to_phys(SW'((ROWS - 1) * COLS) + SW'(swp_q), top_q);
                if (swp_q == ADDR_W'(COLS - 1)) begin
                    state_d = S_IDLE;
                    swp_d   = '0;
                end else begin
                    swp_d = swp_q + ADDR_W'(1);
                end
            end
            default: if (accept) begin
                if (printable) begin
                    we    = 1'b1;
                    waddr = to_phys(cur_lin, top_q);
                    wdata = {cmd_ch_i, cmd_color_i};
                    if (cx_q == XW'(COLS - 1)) begin
                        cx_d     = '0;
                        new_line = 1'b1;
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end else begin
                    case (cmd_ch_i)
                        CW'(10): begin
                            cx_d     = '0;
                            new_line = 1'b1;
                        end
                        CW'(13): cx_d = '0;
                        CW'(8): if (cx_q != '0) begin
                            cx_d  = cx_q - XW'(1);
                            we    = 1'b1;
                            waddr = to_phys(cur_lin - SW'(1), top_q);
                        end
                        CW'(12): begin
                            cx_d    = '0;
                            cy_d    = '0;
                            top_d   = '0;
                            swp_d   = '0;
                            state_d = S_CLEAR;
                        end
                        default: ;
                    endcase
                end
                if (new_line) begin
                    if (cy_q == YW'(ROWS - 1)) begin
                        top_d   = (top_q == YW'(ROWS - 1)) ? '0 : top_q + YW'(1);
                        swp_d   = '0;
                        state_d = S_SCROLL;
                    end else begin
                        cy_d = cy_q + YW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_lin  = SW'(vga_addr_i);
        rd_in   = (rd_lin < CELLS_S);
        rd_phys = rd_in ? to_phys(rd_lin, top_q) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_CLEAR;
            swp_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            top_q   <= '0;
            oob_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            swp_q   <= swp_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            top_q   <= top_d;
            oob_q   <= ~rd_in;
        end
    end

    // Read-first RAM: a same-cycle write to the read address returns old data.
    always_ff @(posedge clk_i) begin
        if (we && !rst_i) mem_q[waddr] <= wdata;
        rd_q <= mem_q[rd_phys];
    end

    assign ch_o    = oob_q ? CW'(32) : rd_q[2*CW-1:CW];
    assign color_o = oob_q ? CW'(0)  : rd_q[CW-1:0];

endmodule

// File: tb/tb_vga_text_console.sv
// Directed + randomized bench for vga_text_console against a row-list screen model.
module tb_vga_text_console;
    localparam int COLS = 96, ROWS = 32, CELLS = COLS * ROWS;

    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [7:0] cmd_ch = 8'd0, cmd_color = 8'd0;
    logic [11:0] vga_addr = 12'd0;
    logic       cmd_ready, busy;
    logic [7:0] ch, color;
    logic [6:0] cx;
    logic [4:0] cy;

    int checks = 0, failures = 0;
    logic [15:0] scr [ROWS][COLS];
    int mx = 0, my = 0;

    vga_text_console dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ch_i(cmd_ch), .cmd_color_i(cmd_color), .vga_addr_i(vga_addr),
        .ch_o(ch), .color_o(color), .cursor_x_o(cx), .cursor_y_o(cy), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Screen model: logical rows; a scroll shifts rows up and blanks the last.
    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = {8'd32, 8'd0};
    endtask

    task automatic model_newline(output int blen);
        blen = 0;
        if (my == ROWS - 1) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = {8'd32, 8'd0};
            blen = COLS;
        end else my++;
    endtask

    task automatic model_apply(input int c, input int col, output int blen);
        blen = 0;
        if ((c >= 32 && c <= 126) || c <= 7 || c == 9 || c == 11) begin
            scr[my][mx] = {8'(c), 8'(col)};
            if (mx == COLS - 1) begin
                mx = 0;
                model_newline(blen);
            end else mx++;
        end else if (c == 10) begin
            mx = 0;
            model_newline(blen);
        end else if (c == 13) mx = 0;
        else if (c == 8) begin
            if (mx > 0) begin
                mx--;
                scr[my][mx] = {8'd32, 8'd0};
            end
        end else if (c == 12) begin
            mx = 0; my = 0;
            model_clear();
            blen = CELLS;
        end
    endtask

    // Counts busy cycles while offering junk bytes that must not be taken.
    task automatic wait_busy(input string tag, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < exp + 100) begin
            cmd_valid = 1'b1; cmd_ch = 8'h41; cmd_color = 8'd3;
            n++;
            step();
        end
        cmd_valid = 1'b0;
        chk(tag, 32'(n), 32'(exp));
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_x"}, 32'(cx), 32'(mx));
        chk({tag, "_y"}, 32'(cy), 32'(my));
    endtask

    task automatic send(input int c, input int col, input bit wait_done = 1'b1);
        int blen;
        chk("ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_ch = 8'(c); cmd_color = 8'(col);
        step();
        cmd_valid = 1'b0;
        model_apply(c, col, blen);
        chk_cursor("send");
        if (!wait_done) return;
        if (blen > 0) wait_busy("sweep_len", blen);
        else chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_cell(input int addr);
        logic [15:0] exp;
        vga_addr = 12'(addr);
        step();
        exp = (addr < CELLS) ? scr[addr / COLS][addr % COLS] : {8'd32, 8'd0};
        chk("cell", 32'({ch, color}), 32'(exp));
    endtask

    task automatic check_all();
        for (int a = 0; a <= CELLS; a++) check_cell(a);
    endtask

    task automatic rand_byte(output int c);
        int k, v;
        k = $urandom_range(0, 9);
        if (k <= 4) c = $urandom_range(32, 126);
        else if (k == 5) begin
            v = $urandom_range(0, 9);
            c = (v < 8) ? v : ((v == 8) ? 9 : 11);
        end
        else if (k == 6) c = 10;
        else if (k == 7) c = 13;
        else if (k == 8) c = 8;
        else c = $urandom_range(0, 1) ? $urandom_range(14, 31) : $urandom_range(127, 255);
    endtask

    initial begin
        int c;
        // reset and power-on clear
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cx", 32'(cx), 32'd0);
        chk("rst_cy", 32'(cy), 32'd0);
        chk("rst_ch", 32'(ch), 32'd32);
        chk("rst_color", 32'(color), 32'd0);
        model_clear(); mx = 0; my = 0;
        wait_busy("rst_clear_len", CELLS);
        check_all();
        check_cell(4095);

        // single printable write
        send(65, 2);
        chk("t2_cx", 32'(cx), 32'd1);
        check_cell(0);

        // full-row wrap
        send(13, 0);
        repeat (96) send(88, $urandom_range(0, 6));
        chk("t3_cx", 32'(cx), 32'd0);
        chk("t3_cy", 32'(cy), 32'd1);
        check_cell(95);
        check_cell(96);

        // randomized byte stream with scrolls
        for (int i = 0; i < 400; i++) begin
            rand_byte(c);
            send(c, $urandom_range(0, 6));
        end
        check_all();

        // LF on the last row at column 4
        while (my != ROWS - 1) send(10, 0);
        send(13, 0);
        repeat (4) send($urandom_range(33, 126), $urandom_range(0, 6));
        chk("t4_cx", 32'(cx), 32'd4);
        chk("t4_cy", 32'(cy), 32'd31);
        send(10, 0);
        chk("t4_cx2", 32'(cx), 32'd0);
        chk("t4_cy2", 32'(cy), 32'd31);
        check_all();

        // form feed
        send(12, 0);
        check_all();

        // backspace at column 0 and mid-row
        repeat (5) send(10, 0);
        send(8, 0);
        chk("t5_bs0_x", 32'(cx), 32'd0);
        chk("t5_bs0_y", 32'(cy), 32'd5);
        send(66, 1); send(67, 4); send(68, 6);
        send(8, 0);
        chk("t5_bs_x", 32'(cx), 32'd2);
        check_cell(5 * 96 + 2);
        check_cell(5 * 96 + 1);

        // reset in the middle of a scroll sweep
        repeat (26) send(10, 0);
        send(90, 5);
        send(10, 0, 1'b0);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear(); mx = 0; my = 0;
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_ready", 32'(cmd_ready), 32'd0);
        chk_cursor("rst2");
        wait_busy("rst2_clear_len", CELLS);
        check_all();
        send(72, 3);
        check_cell(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
